mdu: RTL and testbench
======================

# mdu

Multiply/divide unit in the E stage of the five-stage MIPS pipeline. It consumes the start pulse and operation select that the decoder produces for mult, multu, div, divu, mthi and mtlo. It holds the architectural HI/LO registers and returns HI or LO for mfhi/mflo. It reports `busy` so the hazard unit can stall any MDU-using instruction in D while an operation is in flight.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy duration of mult/multu.
- `DIV_CYCLES`, 10: busy duration of div/divu.

Ports:
- `clk` input 1: clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-low. `reset==0` at a rising edge clears all state.
- `start` input 1: one-cycle launch of mult/multu/div/divu.
- `md_op` input 3: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op.
- `we` input 1: write strobe for mthi/mtlo. It is ignored for other `md_op` values.
- `rs_val` input 32: forwarded operand A, or the mthi/mtlo source.
- `rt_val` input 32: forwarded operand B.
- `rd_hi` input 1: selects HI (1) or LO (0) onto `md_out`.
- `busy` output 1: an operation is in flight.
- `md_out` output 32: combinational read of HI or LO, per `rd_hi`.

## Operation
- State:
  - `hi`, `lo` (32 b each).
  - `pend_hi`, `pend_lo` (32 b each): the result computed at launch.
  - `cnt` (4 b down-counter).
  - `pend_valid` (1 b).
- `busy` = (`cnt` != 0).
- Launch: `start==1` and `busy==0` at an edge, with `md_op` 0–3.
  - mult: `{pend_hi,pend_lo}` = signed(rs) × signed(rt), full 64 b.
  - multu: same as mult, unsigned.
  - div: `pend_lo` = signed quotient, truncated toward zero. `pend_hi` = remainder, which takes the sign of the dividend.
  - divu: same split, unsigned.
  - `cnt` loads `MULT_CYCLES` or `DIV_CYCLES`.
  - `pend_valid` = 1, except for div/divu with `rt_val==0`, where `pend_valid` = 0.
- Divide by zero: the counter still runs the full `DIV_CYCLES`. HI/LO are left unchanged.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Countdown: while `cnt` != 0, `cnt` decrements each edge. On the edge where `cnt` goes 1→0, if `pend_valid`, `hi`/`lo` take `pend_hi`/`pend_lo`; then `pend_valid` clears.
- mthi/mtlo: with `we==1`, `busy==0` and `md_op` 4 or 5, `hi` or `lo` takes `rs_val` at the edge. `start` must be 0 for these ops.
- Illegal overlap: `start` or `we` while `busy==1` is ignored, with no state change. The hazard unit guarantees this does not occur; the verification bench checks it with an assertion.
- `start` with `md_op` 4–7 is ignored.
- Reset (`reset==0` at an edge) clears `hi`, `lo`, `pend_*` and `cnt` to 0, and `pend_valid` to 0. This applies mid-operation as well; the in-flight result is discarded.

## Timing
- Reset values: `busy`=0 and `md_out`=0 (HI=LO=0).
- Launch at edge E0:
  - `busy`=1 from E0 through E0+N−1, i.e. exactly N cycles, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - At edge E0+N, `busy` falls and the new HI/LO become visible on `md_out` in the same cycle.
- Back-to-back: a new `start` is legal in the cycle `busy` is first 0. It launches at edge E0+N+1 at the earliest.
- mthi/mtlo: 1-cycle write; the value is readable on `md_out` the cycle after the edge.
- `md_out` has no internal bypass of a same-cycle mthi/mtlo write. The pipeline forwards such values itself.
- Hazard contract: the decoder/hazard unit stalls D when `useMultDiv & (start_E | busy)`. `mdu` exports only `busy`.

## Test plan
- Signed mult:
  - Stimulus: reset, then start `md_op`=0 with rs=0xFFFFFFFE (−2) and rt=3.
  - Response: `busy` high for 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Reading with `rd_hi`=0 gives 0xFFFFFFFA.
- Unsigned mult:
  - Stimulus: multu with rs=0xFFFFFFFF, rt=0xFFFFFFFF.
  - Response: after 5 cycles, HI=0xFFFFFFFE, LO=0x00000001.
- Signed div and unsigned div:
  - div with rs=−7 (0xFFFFFFF9), rt=2 → `busy` for 10 cycles, then LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - divu with the same operands → LO=0x7FFFFFFC, HI=1.
- Divide by zero and overflow:
  - Preload HI=0x11, LO=0x22 via mthi/mtlo.
  - div by 0 → `busy` for 10 cycles, and HI/LO remain 0x11/0x22.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Illegal overlap: issue `start` (mult 2×2) and mtlo (0xABCD) while `busy`=1 from a prior div 9/4. Both are ignored; the final result is LO=2, HI=1.
- Reset mid-operation:
  - Pull `reset` low for one edge 3 cycles into a mult.
  - Response: `busy`=0 the next cycle, HI=LO=0, and no late write-back afterward.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs a fixed-latency
// mult/div countdown and commits the precomputed result when it expires.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        we,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_hi,
    output logic        busy,
    output logic [31:0] md_out
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] pend_hi_q, pend_hi_d;
    logic [DATA_W-1:0] pend_lo_q, pend_lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_valid_q, pend_valid_d;

    logic                is_signed;
    logic                is_mult;
    logic [2*DATA_W-1:0] mul_a, mul_b, product;
    logic                neg_a, neg_b;
    logic [DATA_W-1:0]   abs_a, abs_b, quot_u, rem_u, quot, rem;

    assign busy   = (cnt_q != '0);
    assign md_out = rd_hi ? hi_q : lo_q;

    // One shared datapath; ops 0 and 2 are the signed variants
    always_comb begin
        is_signed = ~md_op[0];
        is_mult   = (md_op == OP_MULT) || (md_op == OP_MULTU);
        mul_a     = {{DATA_W{is_signed & rs_val[DATA_W-1]}}, rs_val};
        mul_b     = {{DATA_W{is_signed & rt_val[DATA_W-1]}}, rt_val};
        product   = mul_a * mul_b;
        neg_a     = is_signed & rs_val[DATA_W-1];
        neg_b     = is_signed & rt_val[DATA_W-1];
        abs_a     = neg_a ? (DATA_W'(0) - rs_val) : rs_val;
        abs_b     = neg_b ? (DATA_W'(0) - rt_val) : rt_val;
        // Zero divisor result is discarded; avoid dividing by zero at all
        if (rt_val == '0) begin
            abs_b = DATA_W'(1);
        end
        quot_u    = abs_a / abs_b;
        rem_u     = abs_a % abs_b;
        quot      = (neg_a ^ neg_b) ? (DATA_W'(0) - quot_u) : quot_u;
        rem       = neg_a ? (DATA_W'(0) - rem_u) : rem_u;
    end

    // Next-state: countdown/commit while busy, otherwise launch or mthi/mtlo
    always_comb begin
        hi_d         = hi_q;
        lo_d         = lo_q;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;

        if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                if (pend_valid_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
                pend_valid_d = 1'b0;
            end
        end else if (start && !md_op[2]) begin
            if (is_mult) begin
                pend_hi_d    = product[2*DATA_W-1:DATA_W];
                pend_lo_d    = product[DATA_W-1:0];
                cnt_d        = CNT_W'(MULT_CYCLES);
                pend_valid_d = 1'b1;
            end else begin
                pend_hi_d    = rem;
                pend_lo_d    = quot;
                cnt_d        = CNT_W'(DIV_CYCLES);
                pend_valid_d = (rt_val != '0);
            end
        end else if (we && (md_op == OP_MTHI)) begin
            hi_d = rs_val;
        end else if (we && (md_op == OP_MTLO)) begin
            lo_d = rs_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q         <= '0;
            lo_q         <= '0;
            pend_hi_q    <= '0;
            pend_lo_q    <= '0;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: a behavioural HI/LO model feeds a scoreboard
// queue at launch; entries are popped and compared when busy drops.
module tb_mdu;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, we, rd_hi;
    logic [2:0]  md_op;
    logic [31:0] rs_val, rt_val;
    logic        busy;
    logic [31:0] md_out;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .we(we),
        .rs_val(rs_val), .rt_val(rt_val), .rd_hi(rd_hi),
        .busy(busy), .md_out(md_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] r_hi, r_lo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
        rd_hi = 1'b1;
        #1 h = md_out;
        rd_hi = 1'b0;
        #1 l = md_out;
    endtask

    // Behavioural reference: updates the model HI/LO and queues the expectation
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t            e;
        longint          sp;
        longint unsigned up;
        int              sq, sr;
        case (op)
            3'd0: begin
                sp = longint'(int'(a)) * longint'(int'(b));
                m_hi = sp[63:32]; m_lo = sp[31:0];
            end
            3'd1: begin
                up = {32'b0, a} * {32'b0, b};
                m_hi = up[63:32]; m_lo = up[31:0];
            end
            3'd2: begin
                if (b == 32'd0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = 32'd0;
                end else begin
                    sq = int'(a) / int'(b);
                    sr = int'(a) % int'(b);
                    m_lo = sq; m_hi = sr;
                end
            end
            default: begin
                if (b != 32'd0) begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
        endcase
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.cyc = (op < 3'd2) ? MC : DC;
        sb.push_back(e);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        step();
        start = 1'b0;
        md_op = 3'd6;
    endtask

    // Counts busy cycles (bounded), then pops and compares the scoreboard entry
    task automatic finish_op(input string tag, input int already,
                             output logic [31:0] h, output logic [31:0] l);
        exp_t e;
        int   n = already;
        while (busy && n < 40) begin
            n++;
            step();
        end
        read_hl(h, l);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_busy_cycles"}, n, e.cyc);
            check({tag, "_hi"}, h, e.hi);
            check({tag, "_lo"}, l, e.lo);
        end
    endtask

    task automatic write_hl(input logic [2:0] op, input logic [31:0] v);
        we = 1'b1; md_op = op; rs_val = v;
        if (op == 3'd4) m_hi = v; else m_lo = v;
        step();
        we = 1'b0; md_op = 3'd6;
    endtask

    initial begin
        int       busy_seen;
        logic [2:0] rop;
        logic [31:0] ra, rb;

        reset = 1'b0; start = 1'b0; we = 1'b0; rd_hi = 1'b0;
        md_op = 3'd6; rs_val = '0; rt_val = '0;
        step(); step();
        reset = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        read_hl(r_hi, r_lo);
        check("rst_hi", r_hi, 32'd0);
        check("rst_lo", r_lo, 32'd0);

        // Signed and unsigned multiply
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        finish_op("mult", 0, r_hi, r_lo);
        check("mult_hi_const", r_hi, 32'hFFFF_FFFF);
        check("mult_lo_const", r_lo, 32'hFFFF_FFFA);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu", 0, r_hi, r_lo);
        check("multu_hi_const", r_hi, 32'hFFFF_FFFE);
        check("multu_lo_const", r_lo, 32'h0000_0001);

        // Signed and unsigned divide
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        finish_op("div", 0, r_hi, r_lo);
        check("div_hi_const", r_hi, 32'hFFFF_FFFF);
        check("div_lo_const", r_lo, 32'hFFFF_FFFD);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        finish_op("divu", 0, r_hi, r_lo);
        check("divu_hi_const", r_hi, 32'h0000_0001);
        check("divu_lo_const", r_lo, 32'h7FFF_FFFC);

        // mthi/mtlo, then divide by zero leaves them intact
        write_hl(3'd4, 32'h11);
        write_hl(3'd5, 32'h22);
        read_hl(r_hi, r_lo);
        check("mthi", r_hi, 32'h11);
        check("mtlo", r_lo, 32'h22);

        issue(3'd2, 32'd100, 32'd0);
        finish_op("div0", 0, r_hi, r_lo);
        check("div0_hi_const", r_hi, 32'h11);
        check("div0_lo_const", r_lo, 32'h22);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", 0, r_hi, r_lo);
        check("div_ovf_hi_const", r_hi, 32'h0);
        check("div_ovf_lo_const", r_lo, 32'h8000_0000);

        // Start and mtlo while busy must both be ignored
        issue(3'd2, 32'd9, 32'd4);
        step();
        start = 1'b1; md_op = 3'd0; rs_val = 32'd2; rt_val = 32'd2;
        step();
        start = 1'b0; we = 1'b1; md_op = 3'd5; rs_val = 32'hABCD;
        step();
        we = 1'b0; md_op = 3'd6;
        finish_op("overlap", 3, r_hi, r_lo);
        check("overlap_hi_const", r_hi, 32'd1);
        check("overlap_lo_const", r_lo, 32'd2);
        check("overlap_idle_after", 32'(busy), 32'd0);

        // Back-to-back launch in the first idle cycle
        issue(3'd1, 32'd6, 32'd7);
        finish_op("b2b", 0, r_hi, r_lo);
        check("b2b_lo_const", r_lo, 32'd42);

        // Random operations against the model
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom;
            issue(rop, ra, rb);
            finish_op("rand", 0, r_hi, r_lo);
        end

        // Reset three cycles into a mult discards it
        start = 1'b1; md_op = 3'd0; rs_val = 32'd7; rt_val = 32'd9;
        step();
        start = 1'b0; md_op = 3'd6;
        step(); step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        check("midrst_busy", 32'(busy), 32'd0);
        read_hl(r_hi, r_lo);
        check("midrst_hi", r_hi, 32'd0);
        check("midrst_lo", r_lo, 32'd0);
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (busy) busy_seen++;
        end
        check("midrst_no_busy", 32'(busy_seen), 32'd0);
        read_hl(r_hi, r_lo);
        check("midrst_late_hi", r_hi, 32'd0);
        check("midrst_late_lo", r_lo, 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
